bin2bcd_seq: RTL
================

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16: binary input width; legal range 4..26, so any result fits 8 BCD digits.
REQ-002 SHALL have input clk, 1 bit: rising-edge clock; the single clock domain.
REQ-003 SHALL have input reset, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have input start, 1 bit: conversion request; sampled only in IDLE.
REQ-005 SHALL have input bin, WIDTH bits: unsigned binary value; captured on the accepted start cycle only.
REQ-006 SHALL have output busy, 1 bit: high while a conversion is in progress.
REQ-007 SHALL have output done, 1 bit: one-cycle pulse when a new result is valid.
REQ-008 SHALL have output bcd_l, 16 bits: BCD digits 3..0, digit 0 in [3:0]; matches the display stage's low nibble input.
REQ-009 SHALL have output bcd_h, 16 bits: BCD digits 7..4, digit 4 in [3:0]; matches the display stage's high nibble input.
REQ-010 SHALL have output lz_mask, 8 bits: bit i=1 when digit i is a leading zero (blank candidate).

Function
REQ-011 SHALL implement the FSM states IDLE, SHIFT and DONE, all outputs registered.
REQ-012 SHALL, in IDLE with start=1 at cycle N, capture bin, load the iteration counter with WIDTH, clear the 32-bit BCD working register and enter SHIFT; busy=1 from N+1.
REQ-013 SHALL, in each SHIFT cycle, add 3 to every working digit that is >=5, then shift {working, bin_shift} left by one, the bin MSB entering digit 0 bit 0; counter decrements by 1.
REQ-014 SHALL stay in SHIFT for exactly WIDTH cycles (N+1..N+WIDTH), then enter DONE.
REQ-015 SHALL, on entry to DONE (cycle N+WIDTH+1), update bcd_l, bcd_h and lz_mask together, assert done=1 and drop busy=0; latency from start to done is WIDTH+1 cycles.
REQ-016 SHALL return from DONE to IDLE after one cycle; done SHALL never be high for 2 consecutive cycles.
REQ-017 SHALL ignore start in SHIFT and DONE; there is no queueing, and changes on bin outside the accepted start cycle have no effect.
REQ-018 SHALL hold bcd_l, bcd_h and lz_mask stable between done pulses, including during a following conversion.
REQ-019 SHALL accept back-to-back requests: start high continuously gives one conversion every WIDTH+2 cycles.
REQ-020 SHALL set lz_mask bit i (i=7..1) = 1 iff digit i and all higher digits are 0; bit 0 SHALL always be 0, so value 0 shows a single "0".
REQ-021 SHALL drive digits above the maximum needed for WIDTH to 0, and SHALL NOT overflow for any bin in range.

Reset
REQ-022 SHALL, on reset=1 at a clock edge in any state (including mid-SHIFT), go to IDLE with busy=0, done=0, bcd_l=16'h0000, bcd_h=16'h0000, lz_mask=8'b11111110; any partial result is discarded.
REQ-023 SHALL ignore start in a cycle where reset=1.

Verification
REQ-024 SHALL pass this test: WIDTH=16, bin=1234, start at N -> busy N+1..N+16; at N+17 done=1, bcd_l=16'h1234, bcd_h=16'h0000, lz_mask=8'b11110000.
REQ-025 SHALL pass this test: WIDTH=16, bin=65535 -> bcd_h=16'h0006, bcd_l=16'h5535, lz_mask=8'b11100000; bin=0 -> all digits 0, lz_mask=8'b11111110.
REQ-026 SHALL pass this test: WIDTH=26, bin=67108863 -> at N+27 bcd_h=16'h6710, bcd_l=16'h8863, lz_mask=8'h00.
REQ-027 SHALL pass this test: start asserted at N+5 with bin changed during the conversion -> ignored; result reflects bin captured at N, exactly one done pulse.
REQ-028 SHALL pass this test: reset at N+8 of a conversion -> next cycle IDLE, busy=0, outputs at reset values, no done; a fresh start then converts correctly.
REQ-029 SHALL pass this test: start held high continuously with WIDTH=16 -> done pulses every 18 cycles, each reflecting bin at its accept cycle.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using the shift-and-add-3 method, one bit per cycle.
// Results hold steady between done pulses; leading-zero mask helps the display stage blank digits.
module bin2bcd_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [15:0]      bcd_l,
  output logic [15:0]      bcd_h,
  output logic [7:0]       lz_mask
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [31:0]      work_q, work_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [15:0]      bcd_l_q, bcd_l_d;
  logic [15:0]      bcd_h_q, bcd_h_d;
  logic [7:0]       lz_q, lz_d;

  logic [31:0]      adj;
  logic [31:0]      shifted;
  logic [7:0]       lz_next;
  logic             zero_above;

  // One conversion step: add-3 correction, then shift in the next binary MSB
  always_comb begin
    adj = work_q;
    for (int j = 0; j < 8; j++) begin
      if (adj[4*j +: 4] >= 4'd5) begin
        adj[4*j +: 4] = adj[4*j +: 4] + 4'd3;
      end
    end
    shifted = 32'({adj, bin_q[WIDTH-1]});
  end

  // Leading-zero mask of the value about to be published; digit 0 is never blanked
  always_comb begin
    lz_next    = 8'h00;
    zero_above = 1'b1;
    for (int i = 7; i >= 1; i--) begin
      zero_above = zero_above && (shifted[4*i +: 4] == 4'd0);
      lz_next[i] = zero_above;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    work_d  = work_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bcd_l_d = bcd_l_q;
    bcd_h_d = bcd_h_q;
    lz_d    = lz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d   = bin;
          cnt_d   = CNT_W'(WIDTH);
          work_d  = 32'h0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        work_d = shifted;
        bin_d  = {bin_q[WIDTH-2:0], 1'b0};
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          bcd_l_d = shifted[15:0];
          bcd_h_d = shifted[31:16];
          lz_d    = lz_next;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      work_q  <= 32'h0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_l_q <= 16'h0000;
      bcd_h_q <= 16'h0000;
      lz_q    <= 8'b1111_1110;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      work_q  <= work_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_l_q <= bcd_l_d;
      bcd_h_q <= bcd_h_d;
      lz_q    <= lz_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_l   = bcd_l_q;
  assign bcd_h   = bcd_h_q;
  assign lz_mask = lz_q;

endmodule
